// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word address
// and captures the returned word into the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] COUNT_MAX = '1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;
  logic            fetch_fault_q, fetch_fault_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] pc_plus4;

  // Next-state for PC and IF/ID; redirect overrides stall, flush/redirect bubble IF/ID
  always_comb begin
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_inst_d     = if_inst_q;
    if_valid_d    = if_valid_q;
    fetch_fault_d = fetch_fault_q;
    fetch_count_d = fetch_count_q;
    pc_plus4      = pc_q + PC_STEP;

    if (redirect_valid) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end

    if (redirect_valid || flush) begin
      if_valid_d = 1'b0;
      if_inst_d  = '0;
    end else if (!stall) begin
      if_valid_d    = 1'b1;
      if_inst_d     = imem_data;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_plus4;
      if (fetch_count_q != COUNT_MAX) begin
        fetch_count_d = fetch_count_q + XLEN'(1);
      end
    end

    if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      fetch_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      if_pc_q       <= '0;
      if_pc_plus4_q <= PC_STEP;
      if_inst_q     <= '0;
      if_valid_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_inst_q     <= if_inst_d;
      if_valid_q    <= if_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Address comes straight from the PC register, never from the control inputs
  assign imem_addr   = pc_q[31:2];
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS CPU. Sits directly upstream of inst_memory.
- Holds the program counter and drives inst_memory's 30-bit word address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages, and flags misaligned redirect targets.

Parameters:
- RESET_PC, 32'h00400000: byte address loaded into PC on reset. Word address 0x00100000 is the base of instruction memory.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- flush  input  1  squash the instruction entering IF/ID (insert bubble).
- redirect_valid  input  1  branch/jump taken; load PC from redirect_target.
- redirect_target  input  32  byte-address target of the redirect.
- imem_addr  output  30  word address to instruction memory; equals pc[31:2].
- imem_data  input  32  instruction word from instruction memory (combinational read).
- if_pc  output  32  byte PC of the instruction held in IF/ID.
- if_pc_plus4  output  32  if_pc + 4, for link/branch computation.
- if_inst  output  32  instruction held in IF/ID; 32'h00000000 (NOP) when not valid.
- if_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky flag: a redirect target had nonzero bits [1:0].
- fetch_count  output  32  number of valid instructions captured into IF/ID; saturating.

Behaviour:
- Internal pc register (32 bits). imem_addr = pc[31:2] combinationally. pc[1:0] is always 2'b00.
- Fetch latency is one cycle: the word at pc is captured into IF/ID at the next rising edge.
- Reset, checked on each rising edge with reset=1:
  - pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, if_pc_plus4=4, fetch_fault=0, fetch_count=0.
  - Reset asserted mid-operation discards all in-flight state the same way.
- Priority per edge: reset > redirect_valid > stall > normal. flush is evaluated independently for IF/ID.
- PC update:
  - redirect_valid=1: pc <= {redirect_target[31:2],2'b00}, regardless of stall.
  - Else if stall=1: pc holds.
  - Else: pc <= pc + 4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000 with no fault.
- IF/ID update:
  - redirect_valid=1 or flush=1: if_valid<=0, if_inst<=0, if_pc/if_pc_plus4 hold. This holds even when stall=1 (flush wins over stall).
  - Else if stall=1: all IF/ID outputs hold.
  - Else: if_valid<=1, if_inst<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4.
- fetch_fault: set on any edge where redirect_valid=1 and redirect_target[1:0]!=0. Stays set until reset. Fetch continues from the aligned target.
- fetch_count: increments by 1 on each edge where if_valid is loaded with 1. Holds at 32'hFFFFFFFF once reached.
- Simultaneous redirect+stall+flush: PC redirected, IF/ID bubbled, count unchanged.
- No combinational path from stall, flush or redirect_* to imem_addr. It depends only on the pc register.

Test Plan:
1. Reset sequence: hold reset 2 cycles, then release. Required: imem_addr=30'h00100000 during and after reset; if_valid=0 until the first edge after release. The following edges give if_pc=0x00400000, 0x00400004, 0x00400008 with if_inst matching memory words 0x00100000, 0x00100001, 0x00100002; fetch_count=3.
2. Stall: with pc=0x00400008, assert stall for 3 cycles. Required: imem_addr stays 0x00100002; if_pc stays 0x00400004; fetch_count unchanged. After release, if_pc=0x00400008 next edge.
3. Redirect: redirect_valid=1, target=0x00400040 for one cycle. Required: next edge if_valid=0, if_inst=0, imem_addr=0x00100010. Edge after that: if_pc=0x00400040, if_valid=1. fetch_fault stays 0.
4. Misaligned redirect: target=0x00400023. Required: pc becomes 0x00400020; fetch_fault=1 and remains 1 through later aligned redirects until reset.
5. Flush during stall: stall=1 and flush=1 together. Required: pc holds, if_valid=0. Then with stall=0, flush=0 the held instruction is re-fetched and if_valid=1.
6. Wraparound and reset mid-run: redirect to 0xFFFFFFFC. Required: next pc=0x00000000 and fetch_fault=0. Then assert reset during active fetch; required: all outputs return to reset values on that edge.
